wb_cmd_master: RTL and testbench

//  Wishbone classic single-transfer bus initiator. Accepts one read/write command on a

---
 rtl/wb_cmd_master.sv | 189 ++++++++++++++++++
 tb/tb_wb_cmd_master.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_cmd_master.sv
// -----------------------------------------------------------------------------
// wb_cmd_master
//   Wishbone classic single-transfer initiator. Takes one read/write command on
//   a valid/ready command port, runs exactly one CYC/STB cycle on the bus with a
//   bounded wait for ACK/ERR, and returns read data plus status on a
//   valid/ready response port. Lets sequencers and boot logic poke WB
//   peripherals without a CPU.
//
//   Handshake rule for both ports: a transfer happens on a rising clock edge
//   where valid and ready are both 1. A producer holds valid and payload
//   stable until that edge. Here cmd_ready is high only in IDLE, and
//   rsp_valid/rsp_* stay constant in RESP until rsp_ready is seen.
//
// Ports
//   clk, rst               clock (rising edge), async active-high reset
//   cmd_valid/cmd_ready    command handshake
//   cmd_we/adr/sel/dat     command payload (1 = write)
//   rsp_valid/rsp_ready    response handshake
//   rsp_dat/err/tmo        read data (0 for writes/aborts), ERR, timeout flags
//   busy                   1 whenever the FSM is not IDLE
//   o_wb_*/i_wb_*          Wishbone classic master side
//   dbg_state_o            current FSM state, for checkers
// -----------------------------------------------------------------------------
module wb_cmd_master #(
   parameter int AW  = 32,
   parameter int DW  = 32,
   parameter int SW  = DW >> 3,
   parameter int TW  = 8,
   parameter int TMO = 200
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic          cmd_we,
   input  logic [AW-1:0] cmd_adr,
   input  logic [SW-1:0] cmd_sel,
   input  logic [DW-1:0] cmd_dat,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [DW-1:0] rsp_dat,
   output logic          rsp_err,
   output logic          rsp_tmo,
   output logic          busy,
   output logic [AW-1:0] o_wb_adr,
   output logic [SW-1:0] o_wb_sel,
   output logic          o_wb_we,
   output logic [DW-1:0] o_wb_dat,
   input  logic [DW-1:0] i_wb_dat,
   output logic          o_wb_cyc,
   output logic          o_wb_stb,
   input  logic          i_wb_ack,
   input  logic          i_wb_err,
   output logic [1:0]    dbg_state_o
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUS  = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   // Count value seen on the last BUS edge before abort; the cycle is
   // therefore held for exactly TMO clocks.
   localparam logic [TW-1:0] TMO_LAST = (TMO == 0) ? '0 : TW'(TMO - 1);

   logic [1:0]    state_q, state_d;
   logic [TW-1:0] cnt_q,   cnt_d;
   logic [AW-1:0] adr_q,   adr_d;
   logic [SW-1:0] sel_q,   sel_d;
   logic          we_q,    we_d;
   logic [DW-1:0] wdat_q,  wdat_d;
   logic          cyc_q,   cyc_d;
   logic          rvalid_q, rvalid_d;
   logic [DW-1:0] rdat_q,  rdat_d;
   logic          err_q,   err_d;
   logic          tmo_q,   tmo_d;
   logic          done;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      adr_d    = adr_q;
      sel_d    = sel_q;
      we_d     = we_q;
      wdat_d   = wdat_q;
      cyc_d    = cyc_q;
      rvalid_d = rvalid_q;
      rdat_d   = rdat_q;
      err_d    = err_q;
      tmo_d    = tmo_q;
      done     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               adr_d   = cmd_adr;
               sel_d   = cmd_sel;
               we_d    = cmd_we;
               // Write data bus is driven to zero for reads.
               wdat_d  = cmd_we ? cmd_dat : '0;
               cyc_d   = 1'b1;
               cnt_d   = '0;
               state_d = S_BUS;
            end
         end
         S_BUS: begin
            cnt_d = cnt_q + 1'b1;
            // ERR has priority over a simultaneous ACK.
            if (i_wb_err) begin
               rdat_d = '0;
               err_d  = 1'b1;
               tmo_d  = 1'b0;
               done   = 1'b1;
            end else if (i_wb_ack) begin
               rdat_d = we_q ? '0 : i_wb_dat;
               err_d  = 1'b0;
               tmo_d  = 1'b0;
               done   = 1'b1;
            end else if ((TMO != 0) && (cnt_q == TMO_LAST)) begin
               rdat_d = '0;
               err_d  = 1'b0;
               tmo_d  = 1'b1;
               done   = 1'b1;
            end
            if (done) begin
               cyc_d    = 1'b0;
               rvalid_d = 1'b1;
               cnt_d    = '0;
               state_d  = S_RESP;
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               rvalid_d = 1'b0;
               state_d  = S_IDLE;
            end
         end
         default: begin
            state_d  = S_IDLE;
            cyc_d    = 1'b0;
            rvalid_d = 1'b0;
            cnt_d    = '0;
         end
      endcase
   end

   // Async reset drops CYC/STB immediately and discards any in-flight command.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         adr_q    <= '0;
         sel_q    <= '0;
         we_q     <= 1'b0;
         wdat_q   <= '0;
         cyc_q    <= 1'b0;
         rvalid_q <= 1'b0;
         rdat_q   <= '0;
         err_q    <= 1'b0;
         tmo_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         adr_q    <= adr_d;
         sel_q    <= sel_d;
         we_q     <= we_d;
         wdat_q   <= wdat_d;
         cyc_q    <= cyc_d;
         rvalid_q <= rvalid_d;
         rdat_q   <= rdat_d;
         err_q    <= err_d;
         tmo_q    <= tmo_d;
      end
   end

   assign cmd_ready   = (state_q == S_IDLE);
   assign busy        = (state_q != S_IDLE);
   assign rsp_valid   = rvalid_q;
   assign rsp_dat     = rdat_q;
   assign rsp_err     = err_q;
   assign rsp_tmo     = tmo_q;
   assign o_wb_adr    = adr_q;
   assign o_wb_sel    = sel_q;
   assign o_wb_we     = we_q;
   assign o_wb_dat    = wdat_q;
   assign o_wb_cyc    = cyc_q;
   assign o_wb_stb    = cyc_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
// -----------------------------------------------------------------------------
// tb_wb_cmd_master
//   Directed bench for wb_cmd_master (TMO = 16). Inputs change and outputs are
//   sampled on the falling edge; the DUT acts on the rising edge.
// -----------------------------------------------------------------------------
module tb_wb_cmd_master;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cmd_valid, cmd_ready, cmd_we;
   logic [AW-1:0] cmd_adr;
   logic [SW-1:0] cmd_sel;
   logic [DW-1:0] cmd_dat;
   logic          rsp_valid, rsp_ready, rsp_err, rsp_tmo, busy;
   logic [DW-1:0] rsp_dat;
   logic [AW-1:0] o_wb_adr;
   logic [SW-1:0] o_wb_sel;
   logic          o_wb_we, o_wb_cyc, o_wb_stb;
   logic [DW-1:0] o_wb_dat, i_wb_dat;
   logic          i_wb_ack, i_wb_err;
   logic [1:0]    dbg_state;

   wb_cmd_master #(.AW(AW), .DW(DW), .SW(SW), .TW(8), .TMO(16)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
      .cmd_adr(cmd_adr), .cmd_sel(cmd_sel), .cmd_dat(cmd_dat),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat),
      .rsp_err(rsp_err), .rsp_tmo(rsp_tmo), .busy(busy),
      .o_wb_adr(o_wb_adr), .o_wb_sel(o_wb_sel), .o_wb_we(o_wb_we),
      .o_wb_dat(o_wb_dat), .i_wb_dat(i_wb_dat), .o_wb_cyc(o_wb_cyc),
      .o_wb_stb(o_wb_stb), .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err),
      .dbg_state_o(dbg_state)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- scoreboard counters ----------------
   int n_tests = 0;
   int n_fail  = 0;
   int cyc_hi_cnt = 0;
   int rd_dat_bad = 0;
   int rsp_cnt    = 0;
   int acc_cnt    = 0;

   always @(negedge clk) begin
      if (o_wb_cyc) cyc_hi_cnt <= cyc_hi_cnt + 1;
      if (o_wb_cyc && !o_wb_we && (o_wb_dat != '0)) rd_dat_bad <= rd_dat_bad + 1;
   end

   always @(posedge clk) begin
      if (rsp_valid && rsp_ready) rsp_cnt <= rsp_cnt + 1;
      if (cmd_valid && cmd_ready) acc_cnt <= acc_cnt + 1;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // ---------------- driver tasks (called on a falling edge) ----------------
   task automatic drive_cmd(input logic we, input logic [AW-1:0] adr,
                            input logic [SW-1:0] sel, input logic [DW-1:0] dat);
      cmd_valid = 1'b1;
      cmd_we    = we;
      cmd_adr   = adr;
      cmd_sel   = sel;
      cmd_dat   = dat;
   endtask

   task automatic take_rsp();
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   // ---------------- main sequence ----------------
   initial begin
      int c0, r0, a0, b0, waited, rdy_seen, bad;
      cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_sel = '0; cmd_dat = '0;
      rsp_ready = 1'b0; i_wb_dat = '0; i_wb_ack = 1'b0; i_wb_err = 1'b0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Reset state
      check("rst_cmd_ready", cmd_ready, 1);
      check("rst_busy",      busy, 0);
      check("rst_cyc",       o_wb_cyc, 0);
      check("rst_stb",       o_wb_stb, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_state",     dbg_state, 0);

      // 1: write, slave acks in the second CYC cycle
      c0 = cyc_hi_cnt;
      drive_cmd(1'b1, 32'h0, 4'hF, 32'h3);
      @(negedge clk);
      cmd_valid = 1'b0;
      check("t1_cyc",   o_wb_cyc, 1);
      check("t1_stb",   o_wb_stb, 1);
      check("t1_adr",   o_wb_adr, 32'h0);
      check("t1_we",    o_wb_we, 1);
      check("t1_dat",   o_wb_dat, 32'h3);
      check("t1_sel",   o_wb_sel, 4'hF);
      check("t1_ready", cmd_ready, 0);
      check("t1_busy",  busy, 1);
      @(negedge clk);
      check("t1_dat_hold", o_wb_dat, 32'h3);
      check("t1_rsp_early", rsp_valid, 0);
      i_wb_ack = 1'b1; i_wb_dat = 32'hDEAD_BEEF;
      @(negedge clk);
      i_wb_ack = 1'b0; i_wb_dat = '0;
      check("t1_rsp_valid", rsp_valid, 1);
      check("t1_cyc_low",   o_wb_cyc, 0);
      check("t1_err",       rsp_err, 0);
      check("t1_tmo",       rsp_tmo, 0);
      check("t1_rsp_dat",   rsp_dat, 32'h0);
      check("t1_cyc_len",   cyc_hi_cnt - c0, 2);
      take_rsp();
      check("t1_busy_end",  busy, 0);
      check("t1_rsp_clr",   rsp_valid, 0);

      // 2: read with 4 wait cycles
      c0 = cyc_hi_cnt; b0 = rd_dat_bad;
      drive_cmd(1'b0, 32'h8, 4'hF, 32'hFFFF_FFFF);
      @(negedge clk);
      cmd_valid = 1'b0;
      check("t2_we",  o_wb_we, 0);
      check("t2_adr", o_wb_adr, 32'h8);
      repeat (4) @(negedge clk);
      i_wb_ack = 1'b1; i_wb_dat = 32'h1234_5678;
      @(negedge clk);
      i_wb_ack = 1'b0; i_wb_dat = '0;
      check("t2_rsp_valid", rsp_valid, 1);
      check("t2_rsp_dat",   rsp_dat, 32'h1234_5678);
      check("t2_err",       rsp_err, 0);
      check("t2_cyc_len",   cyc_hi_cnt - c0, 5);
      check("t2_wdat_zero", rd_dat_bad - b0, 0);
      take_rsp();

      // 3: ERR together with ACK on a read
      drive_cmd(1'b0, 32'h10, 4'hF, 32'h0);
      @(negedge clk);
      cmd_valid = 1'b0;
      i_wb_ack = 1'b1; i_wb_err = 1'b1; i_wb_dat = 32'hCAFE_F00D;
      @(negedge clk);
      i_wb_ack = 1'b0; i_wb_err = 1'b0; i_wb_dat = '0;
      check("t3_rsp_valid", rsp_valid, 1);
      check("t3_err",       rsp_err, 1);
      check("t3_rsp_dat",   rsp_dat, 32'h0);
      check("t3_tmo",       rsp_tmo, 0);
      take_rsp();

      // 4: timeout with a silent slave
      c0 = cyc_hi_cnt;
      drive_cmd(1'b0, 32'h20, 4'hF, 32'h0);
      @(negedge clk);
      cmd_valid = 1'b0;
      waited = 0;
      while (!rsp_valid && waited < 40) begin
         @(negedge clk);
         waited++;
      end
      check("t4_rsp_seen", rsp_valid, 1);
      check("t4_cyc_len",  cyc_hi_cnt - c0, 16);
      check("t4_tmo",      rsp_tmo, 1);
      check("t4_err",      rsp_err, 0);
      check("t4_rsp_dat",  rsp_dat, 32'h0);
      i_wb_ack = 1'b1; i_wb_dat = 32'h5555_AAAA;
      repeat (2) @(negedge clk);
      i_wb_ack = 1'b0; i_wb_dat = '0;
      check("t4_late_tmo", rsp_tmo, 1);
      check("t4_late_dat", rsp_dat, 32'h0);
      check("t4_late_cyc", o_wb_cyc, 0);
      take_rsp();
      check("t4_busy_end", busy, 0);
      i_wb_ack = 1'b1;
      @(negedge clk);
      i_wb_ack = 1'b0;
      @(negedge clk);
      check("t4_idle_ack_rsp", rsp_valid, 0);
      check("t4_idle_ack_busy", busy, 0);

      // 5: response backpressure with the next command already waiting
      r0 = rsp_cnt; a0 = acc_cnt;
      drive_cmd(1'b1, 32'h40, 4'h3, 32'h11);
      @(negedge clk);
      drive_cmd(1'b1, 32'h44, 4'hC, 32'h22);
      check("t5_a_adr", o_wb_adr, 32'h40);
      i_wb_ack = 1'b1;
      @(negedge clk);
      i_wb_ack = 1'b0;
      check("t5_a_rsp", rsp_valid, 1);
      rdy_seen = 0;
      repeat (10) begin
         if (cmd_ready) rdy_seen++;
         @(negedge clk);
      end
      check("t5_ready_held_low", rdy_seen, 0);
      check("t5_rsp_held", rsp_valid, 1);
      rsp_ready = 1'b1;
      check("t5_ready_in_rsp_cycle", cmd_ready, 0);
      @(negedge clk);
      rsp_ready = 1'b0;
      check("t5_ready_after", cmd_ready, 1);
      check("t5_cyc_idle", o_wb_cyc, 0);
      @(negedge clk);
      cmd_valid = 1'b0;
      check("t5_b_cyc", o_wb_cyc, 1);
      check("t5_b_adr", o_wb_adr, 32'h44);
      check("t5_b_dat", o_wb_dat, 32'h22);
      check("t5_b_sel", o_wb_sel, 4'hC);
      i_wb_ack = 1'b1;
      @(negedge clk);
      i_wb_ack = 1'b0;
      check("t5_b_rsp", rsp_valid, 1);
      take_rsp();
      @(negedge clk);
      check("t5_rsp_count", rsp_cnt - r0, 2);
      check("t5_acc_count", acc_cnt - a0, 2);

      // 6: reset while CYC is high
      r0 = rsp_cnt;
      drive_cmd(1'b1, 32'h80, 4'hF, 32'h55);
      @(negedge clk);
      cmd_valid = 1'b0;
      check("t6_cyc_before", o_wb_cyc, 1);
      #1 rst = 1'b1;
      #1;
      check("t6_cyc_async", o_wb_cyc, 0);
      check("t6_stb_async", o_wb_stb, 0);
      check("t6_busy_async", busy, 0);
      @(negedge clk);
      rst = 1'b0;
      bad = 0;
      repeat (3) begin
         @(negedge clk);
         if (rsp_valid) bad++;
      end
      check("t6_no_rsp", bad, 0);
      check("t6_rsp_count", rsp_cnt - r0, 0);
      drive_cmd(1'b0, 32'hC, 4'hF, 32'h0);
      @(negedge clk);
      cmd_valid = 1'b0;
      check("t6_next_cyc", o_wb_cyc, 1);
      check("t6_next_adr", o_wb_adr, 32'hC);
      i_wb_ack = 1'b1; i_wb_dat = 32'hA5A5_0F0F;
      @(negedge clk);
      i_wb_ack = 1'b0; i_wb_dat = '0;
      check("t6_next_rsp", rsp_valid, 1);
      check("t6_next_dat", rsp_dat, 32'hA5A5_0F0F);
      take_rsp();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
